// File: rtl/mux_ff_pkg.sv
// rtl/mux_ff_pkg.sv - shared lane constants, state type and decode helper for the 4:1 mux family
package mux_ff_pkg;

  localparam int LANES = 4;
  localparam int SEL_W = 2;

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } state_t;

  // Decode a lane number into a one-hot lane mask
  function automatic logic [LANES-1:0] onehot(input logic [SEL_W-1:0] s);
    onehot = '0;
    onehot[s] = 1'b1;
  endfunction

endpackage

// File: rtl/demux_lane_reg.sv
// rtl/demux_lane_reg.sv - one lane data register with write enable and synchronous clear
module demux_lane_reg #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             we,
  input  logic             clr,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // resetn is active high here; clear wins over a write in the same cycle
  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (we) begin
      q <= d;
    end
  end

endmodule

// File: rtl/demux_ff_deser.sv
// rtl/demux_ff_deser.sv - 1-to-4 registered demux/deserializer with word handshake
module demux_ff_deser
  import mux_ff_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             auto_mode,
  input  logic [1:0]       sel,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  input  logic             flush,
  output logic [WIDTH-1:0] o0,
  output logic [WIDTH-1:0] o1,
  output logic [WIDTH-1:0] o2,
  output logic [WIDTH-1:0] o3,
  output logic             word_valid,
  input  logic             out_ready,
  output logic [1:0]       lane_idx
);

  state_t             state_q, state_d;
  logic [LANES-1:0]   mask_q, mask_d;
  logic [SEL_W-1:0]   lane_idx_q, lane_idx_d;
  logic               mode_q, mode_d;
  logic               din_ready_q, din_ready_d;
  logic               word_valid_q, word_valid_d;

  logic               accept;
  logic               eff_mode;
  logic [SEL_W-1:0]   target;
  logic [LANES-1:0]   target_oh;
  logic [LANES-1:0]   lane_we;
  logic               lane_clr;
  logic [WIDTH-1:0]   lane_q [LANES];

  // The first beat of a word steers with the live auto_mode; later beats use the latch
  assign accept    = din_valid && din_ready_q && (state_q == FILL);
  assign eff_mode  = (mask_q == '0) ? auto_mode : mode_q;
  assign target    = eff_mode ? lane_idx_q : sel;
  assign target_oh = onehot(target);

  // Control registers; din_ready is held low through reset and rises on the first edge after
  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      state_q      <= FILL;
      mask_q       <= '0;
      lane_idx_q   <= '0;
      mode_q       <= 1'b0;
      din_ready_q  <= 1'b0;
      word_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      mask_q       <= mask_d;
      lane_idx_q   <= lane_idx_d;
      mode_q       <= mode_d;
      din_ready_q  <= din_ready_d;
      word_valid_q <= word_valid_d;
    end
  end

  // Next state: flush overrides everything, then fill/hold handshake
  always_comb begin
    state_d    = state_q;
    mask_d     = mask_q;
    lane_idx_d = lane_idx_q;
    mode_d     = mode_q;
    lane_we    = '0;
    lane_clr   = 1'b0;
    if (flush) begin
      state_d    = FILL;
      mask_d     = '0;
      lane_idx_d = '0;
      lane_clr   = 1'b1;
    end else begin
      case (state_q)
        FILL: begin
          if (accept) begin
            lane_we = target_oh;
            mask_d  = mask_q | target_oh;
            if (mask_q == '0) begin
              mode_d = auto_mode;
            end
            if (eff_mode) begin
              lane_idx_d = lane_idx_q + 2'd1;
            end
            if ((mask_q | target_oh) == '1) begin
              state_d = HOLD;
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            state_d    = FILL;
            mask_d     = '0;
            lane_idx_d = '0;
          end
        end
        default: state_d = FILL;
      endcase
    end
    din_ready_d  = (state_d == FILL);
    word_valid_d = (state_d == HOLD);
  end

  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      demux_lane_reg #(.WIDTH(WIDTH)) u_lane (
        .clk    (clk),
        .resetn (resetn),
        .we     (lane_we[gi]),
        .clr    (lane_clr),
        .d      (din),
        .q      (lane_q[gi])
      );
    end
  endgenerate

  assign o0         = lane_q[0];
  assign o1         = lane_q[1];
  assign o2         = lane_q[2];
  assign o3         = lane_q[3];
  assign din_ready  = din_ready_q;
  assign word_valid = word_valid_q;
  assign lane_idx   = lane_idx_q;

endmodule

// File: tb/tb_demux_ff_deser.sv
// tb/tb_demux_ff_deser.sv - table-driven bench with word scoreboard for demux_ff_deser
module tb_demux_ff_deser;

  logic       clk = 1'b0;
  logic       resetn;
  logic       auto_mode;
  logic [1:0] sel;
  logic       din;
  logic       din_valid;
  logic       din_ready;
  logic       flush;
  logic       o0, o1, o2, o3;
  logic       word_valid;
  logic       out_ready;
  logic [1:0] lane_idx;

  demux_ff_deser #(.WIDTH(1)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .auto_mode  (auto_mode),
    .sel        (sel),
    .din        (din),
    .din_valid  (din_valid),
    .din_ready  (din_ready),
    .flush      (flush),
    .o0         (o0),
    .o1         (o1),
    .o2         (o2),
    .o3         (o3),
    .word_valid (word_valid),
    .out_ready  (out_ready),
    .lane_idx   (lane_idx)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       am;
    logic [1:0] sel;
    logic       rsel;
    logic       din;
    logic       dv;
    logic       fl;
    logic       ordy;
    logic [3:0] eo;
    logic       ewv;
    logic       edr;
    logic [1:0] elane;
  } vec_t;

  vec_t       tbl[$];
  logic [3:0] sb[$];
  int         tests = 0;
  int         fails = 0;
  logic       exp_wv_last = 1'b0;
  logic       wv_seen = 1'b0;

  function automatic vec_t mk(input bit am, input int s, input bit rsel, input bit d,
                              input bit dv, input bit fl, input bit ordy, input logic [3:0] eo,
                              input bit ewv, input bit edr, input int lane);
    vec_t v;
    v.am = am; v.sel = 2'(s); v.rsel = rsel; v.din = d; v.dv = dv; v.fl = fl;
    v.ordy = ordy; v.eo = eo; v.ewv = ewv; v.edr = edr; v.elane = 2'(lane);
    return v;
  endfunction

  task automatic cmp(input string name, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_out(input string name, input vec_t v);
    cmp({name, "_o"}, 8'({o3, o2, o1, o0}), 8'(v.eo));
    cmp({name, "_wv"}, 8'(word_valid), 8'(v.ewv));
    cmp({name, "_dr"}, 8'(din_ready), 8'(v.edr));
    cmp({name, "_lane"}, 8'(lane_idx), 8'(v.elane));
    if (word_valid && !wv_seen) begin
      if (sb.size() == 0) begin
        cmp({name, "_sb_empty"}, 8'(word_valid), 8'd0);
      end else begin
        cmp({name, "_sb_word"}, 8'({o3, o2, o1, o0}), 8'(sb.pop_front()));
      end
    end
    wv_seen = word_valid;
  endtask

  task automatic apply(input vec_t v, input string name);
    @(negedge clk);
    auto_mode = v.am;
    sel       = v.rsel ? 2'($urandom_range(0, 3)) : v.sel;
    din       = v.din;
    din_valid = v.dv;
    flush     = v.fl;
    out_ready = v.ordy;
    if (v.ewv && !exp_wv_last) sb.push_back(v.eo);
    exp_wv_last = v.ewv;
    @(posedge clk);
    #1;
    check_out(name, v);
  endtask

  initial begin
    resetn = 1'b1; auto_mode = 1'b0; sel = 2'd0; din = 1'b0;
    din_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;

    // reset then idle
    repeat (3) @(posedge clk);
    #1;
    cmp("rst_o", 8'({o3, o2, o1, o0}), 8'd0);
    cmp("rst_wv", 8'(word_valid), 8'd0);
    cmp("rst_dr", 8'(din_ready), 8'd0);
    cmp("rst_lane", 8'(lane_idx), 8'd0);
    @(negedge clk);
    resetn = 1'b0;
    @(posedge clk);
    #1;
    cmp("rel_dr", 8'(din_ready), 8'd1);

    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 4'b0000, 0, 1, 0));
    // auto fill 1,0,1,1 then hold, din ignored, handshake, out_ready idle in FILL
    tbl.push_back(mk(1, 0, 0, 1, 1, 0, 0, 4'b0001, 0, 1, 1));
    tbl.push_back(mk(1, 0, 0, 0, 1, 0, 0, 4'b0001, 0, 1, 2));
    tbl.push_back(mk(1, 0, 0, 1, 1, 0, 0, 4'b0101, 0, 1, 3));
    tbl.push_back(mk(1, 0, 0, 1, 1, 0, 0, 4'b1101, 1, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 1, 0, 0, 4'b1101, 1, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 1, 0, 1, 4'b1101, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 4'b1101, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, 4'b0000, 0, 1, 0));
    // addressed, out of order with overwrite of lane 2
    tbl.push_back(mk(0, 2, 0, 1, 1, 0, 0, 4'b0100, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 1, 1, 0, 0, 4'b0101, 0, 1, 0));
    tbl.push_back(mk(0, 2, 0, 0, 1, 0, 0, 4'b0001, 0, 1, 0));
    tbl.push_back(mk(0, 3, 0, 1, 1, 0, 0, 4'b1001, 0, 1, 0));
    tbl.push_back(mk(0, 1, 0, 0, 1, 0, 0, 4'b1001, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 4'b1001, 0, 1, 0));
    // gapped valid, auto latched on first beat then auto_mode dropped with random sel
    tbl.push_back(mk(1, 3, 0, 0, 1, 0, 0, 4'b1000, 0, 1, 1));
    tbl.push_back(mk(0, 0, 1, 1, 0, 0, 0, 4'b1000, 0, 1, 1));
    tbl.push_back(mk(0, 0, 1, 1, 1, 0, 0, 4'b1010, 0, 1, 2));
    tbl.push_back(mk(0, 0, 1, 1, 1, 0, 0, 4'b1110, 0, 1, 3));
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0, 4'b1110, 0, 1, 3));
    tbl.push_back(mk(0, 0, 1, 0, 1, 0, 0, 4'b0110, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 4'b0110, 0, 1, 0));
    // flush mid-word drops the beat, then a clean word, then flush during HOLD handshake
    tbl.push_back(mk(1, 0, 0, 1, 1, 0, 0, 4'b0111, 0, 1, 1));
    tbl.push_back(mk(1, 0, 0, 1, 1, 0, 0, 4'b0111, 0, 1, 2));
    tbl.push_back(mk(1, 0, 0, 1, 1, 1, 0, 4'b0000, 0, 1, 0));
    tbl.push_back(mk(1, 0, 0, 1, 1, 0, 0, 4'b0001, 0, 1, 1));
    tbl.push_back(mk(1, 0, 0, 0, 1, 0, 0, 4'b0001, 0, 1, 2));
    tbl.push_back(mk(1, 0, 0, 0, 1, 0, 0, 4'b0001, 0, 1, 3));
    tbl.push_back(mk(1, 0, 0, 1, 1, 0, 0, 4'b1001, 1, 0, 0));
    tbl.push_back(mk(1, 0, 0, 1, 1, 1, 1, 4'b0000, 0, 1, 0));
    // three beats before an asynchronous reset
    tbl.push_back(mk(1, 0, 0, 1, 1, 0, 0, 4'b0001, 0, 1, 1));
    tbl.push_back(mk(1, 0, 0, 1, 1, 0, 0, 4'b0011, 0, 1, 2));
    tbl.push_back(mk(1, 0, 0, 1, 1, 0, 0, 4'b0111, 0, 1, 3));

    for (int i = 0; i < tbl.size(); i++) begin
      apply(tbl[i], $sformatf("row%0d", i));
    end

    // async reset between edges clears outputs with no clock edge
    #2;
    resetn = 1'b1;
    din_valid = 1'b0;
    #1;
    cmp("arst_o", 8'({o3, o2, o1, o0}), 8'd0);
    cmp("arst_wv", 8'(word_valid), 8'd0);
    cmp("arst_dr", 8'(din_ready), 8'd0);
    cmp("arst_lane", 8'(lane_idx), 8'd0);
    exp_wv_last = 1'b0;
    wv_seen = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    resetn = 1'b0;
    @(posedge clk);
    #1;
    cmp("arel_dr", 8'(din_ready), 8'd1);
    apply(mk(1, 0, 0, 0, 1, 0, 0, 4'b0000, 0, 1, 1), "post0");
    apply(mk(1, 0, 0, 1, 1, 0, 0, 4'b0010, 0, 1, 2), "post1");
    apply(mk(1, 0, 0, 0, 1, 0, 0, 4'b0010, 0, 1, 3), "post2");
    apply(mk(1, 0, 0, 1, 1, 0, 0, 4'b1010, 1, 0, 0), "post3");
    apply(mk(1, 0, 0, 0, 0, 0, 1, 4'b1010, 0, 1, 0), "post4");

    cmp("sb_drain", 8'(sb.size()), 8'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
